// File: rtl/sdram_pkg.sv
// sdram_pkg: types and default widths shared by the SDRAM controller and the
// port arbiter in front of it.
//   SDRAM_NUM_PORTS - default requester count for the arbiter
//   SDRAM_HADDR_W   - host address width (bank+row+col), as seen by the controller
//   SDRAM_DATA_W    - controller data word width
//   SDRAM_TIMEOUT   - default issue-to-completion budget before an error response
//   arb_state_t     - arbiter FSM states
package sdram_pkg;
    localparam int SDRAM_NUM_PORTS = 4;
    localparam int SDRAM_HADDR_W   = 24;
    localparam int SDRAM_DATA_W    = 16;
    localparam int SDRAM_TIMEOUT   = 64;

    typedef enum logic [2:0] {
        ARB,
        ISSUE,
        WAIT_ACCEPT,
        WAIT_DONE,
        RESP
    } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches req starting at ptr+1
// and wrapping, so the port at ptr (the last one served) has the lowest priority.
//   req     - request vector
//   ptr     - index of the previous winner
//   found   - at least one request present
//   gnt_oh  - one-hot winner (zero when found=0)
//   gnt_idx - binary winner index (zero when found=0)
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic                 found,
    output logic [NUM_PORTS-1:0] gnt_oh,
    output logic [PORT_W-1:0]    gnt_idx
);
    always_comb begin
        found   = 1'b0;
        gnt_oh  = '0;
        gnt_idx = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_PORTS]) begin
                found   = 1'b1;
                gnt_idx = PORT_W'((int'(ptr) + k) % NUM_PORTS);
                gnt_oh[(int'(ptr) + k) % NUM_PORTS] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller user interface between
// NUM_PORTS requesters. Round-robin grant, one transaction in flight, and a
// per-transaction timeout that completes with rsp_error=1.
//   req_valid/req_write/req_addr/req_wdata - per-port request (slice i = port i)
//   req_ready   - one-hot accept pulse (transfer on valid&ready)
//   rsp_valid   - one-hot completion pulse to the owning port
//   rsp_error   - qualifies rsp_valid, 1 = timed out
//   rsp_rdata   - read data, meaningful with rsp_valid of a read
//   wr_*/rd_*   - controller command side; rd_data/rd_ready/busy back from it
//   grant_idx   - current/last owner (debug)
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_PORTS      = SDRAM_NUM_PORTS,
    parameter int HADDR_WIDTH    = SDRAM_HADDR_W,
    parameter int DATA_WIDTH     = SDRAM_DATA_W,
    parameter int TIMEOUT_CYCLES = SDRAM_TIMEOUT,
    parameter int PORT_W         = $clog2(NUM_PORTS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  req_valid,
    input  logic [NUM_PORTS-1:0]                  req_write,
    input  logic [NUM_PORTS-1:0][HADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]                  req_ready,
    output logic [NUM_PORTS-1:0]                  rsp_valid,
    output logic                                  rsp_error,
    output logic [DATA_WIDTH-1:0]                 rsp_rdata,
    output logic [HADDR_WIDTH-1:0]                wr_addr,
    output logic [DATA_WIDTH-1:0]                 wr_data,
    output logic                                  wr_enable,
    output logic [HADDR_WIDTH-1:0]                rd_addr,
    output logic                                  rd_enable,
    input  logic [DATA_WIDTH-1:0]                 rd_data,
    input  logic                                  rd_ready,
    input  logic                                  busy,
    output logic [PORT_W-1:0]                     grant_idx
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_t             state_q, state_d;
    logic                   run_q;      // low for the first cycle after reset release
    logic [PORT_W-1:0]      ptr_q;
    logic [PORT_W-1:0]      grant_q;
    logic                   wr_q;
    logic [HADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [TMR_W-1:0]       timer_q;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  rdata_q;

    logic                   any_req;
    logic [NUM_PORTS-1:0]   gnt_oh;
    logic [PORT_W-1:0]      gnt_idx;
    logic                   grant, done, tmo;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .found   (any_req),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    assign grant = (state_q == ARB) && run_q && !busy && any_req;
    assign tmo   = timer_q >= TMR_W'(TIMEOUT_CYCLES - 1);
    // Normal completion; checked ahead of tmo so data arriving on the expiry cycle wins.
    assign done  = (state_q == WAIT_DONE) && (wr_q ? !busy : rd_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:         if (grant) state_d = ISSUE;
            ISSUE:       state_d = WAIT_ACCEPT;
            WAIT_ACCEPT: if (tmo) state_d = RESP;
                         else if (busy) state_d = WAIT_DONE;
            WAIT_DONE:   if (done || tmo) state_d = RESP;
            RESP:        state_d = ARB;
            default:     state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            run_q   <= 1'b0;
            ptr_q   <= PORT_W'(NUM_PORTS - 1);
            grant_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (grant) begin
                ptr_q   <= gnt_idx;
                grant_q <= gnt_idx;
                wr_q    <= req_write[gnt_idx];
                addr_q  <= req_addr[gnt_idx];
                wdata_q <= req_wdata[gnt_idx];
            end
            case (state_q)
                ISSUE: timer_q <= '0;
                WAIT_ACCEPT, WAIT_DONE: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (state_d == RESP) begin
                        err_q   <= !done;
                        rdata_q <= (done && !wr_q) ? rd_data : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = grant ? gnt_oh : '0;
    assign wr_enable = (state_q == ISSUE) && wr_q;
    assign rd_enable = (state_q == ISSUE) && !wr_q;
    assign wr_addr   = addr_q;
    assign rd_addr   = addr_q;
    assign wr_data   = wdata_q;
    assign rsp_valid = (state_q == RESP) ? (NUM_PORTS'(1) << grant_q) : '0;
    assign rsp_error = (state_q == RESP) && err_q;
    assign rsp_rdata = rdata_q;
    assign grant_idx = grant_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: scoreboard bench for sdram_port_arbiter with a small
// controller model (fixed busy/read latency, optional "never busy" mode).
module tb_sdram_port_arbiter;
    localparam int NP = 4;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]         req_valid, req_write, req_ready, rsp_valid;
    logic [NP-1:0][AW-1:0] req_addr;
    logic [NP-1:0][DW-1:0] req_wdata;
    logic                  rsp_error, wr_enable, rd_enable, rd_ready, busy;
    logic [DW-1:0]         rsp_rdata, wr_data, rd_data;
    logic [AW-1:0]         wr_addr, rd_addr;
    logic [1:0]            grant_idx;

    sdram_port_arbiter #(.NUM_PORTS(NP), .HADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
        .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data),
        .rd_ready(rd_ready), .busy(busy), .grant_idx(grant_idx));

    int chk_cnt = 0, pass_cnt = 0;
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Read data the controller model returns for an address.
    function automatic logic [DW-1:0] rdf(logic [AW-1:0] a);
        return a[15:0] ^ 16'h9DAA;
    endfunction

    // ---------------- controller model ----------------
    int          ctl_mode = 0;   // 0 normal, 1 never asserts busy
    int          rd_len = 3;     // read: busy cycles, rd_ready on the last one
    logic        ext_busy = 1'b0;
    int          cnt;
    logic        op_rd;
    logic [AW-1:0] op_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 0; op_rd <= 1'b0; op_addr <= '0;
        end else begin
            if (cnt != 0) cnt <= cnt - 1;
            if ((wr_enable || rd_enable) && ctl_mode == 0) begin
                cnt     <= wr_enable ? 2 : rd_len;
                op_rd   <= rd_enable;
                op_addr <= rd_addr;
            end
        end
    end
    assign busy     = (cnt != 0) || ext_busy;
    assign rd_ready = op_rd && (cnt == 1);
    assign rd_data  = rd_ready ? rdf(op_addr) : ~rdf(op_addr);

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            err;
    } txn_t;
    txn_t iss_q[$], rsp_q[$];
    int   grant_log[$];
    int   ptr_m = NP - 1;
    logic [NP-1:0] acc_mask = '0;
    int   g_cnt = 0, r_cnt = 0, rd_pulses = 0, wr_pulses = 0;
    logic [AW-1:0] last_rd_addr, last_wr_addr;
    logic [DW-1:0] last_wr_data, last_rdata;
    logic [NP-1:0] last_rsp_valid;
    logic          last_err;

    // First valid port after the last winner, wrapping.
    function automatic int model_pick(logic [NP-1:0] v, int p);
        for (int k = 1; k <= NP; k++)
            if (v[(p + k) % NP]) return (p + k) % NP;
        return -1;
    endfunction

    always @(negedge rst_n) begin
        iss_q.delete(); rsp_q.delete();
        ptr_m = NP - 1; acc_mask = '0;
    end

    // grant + response monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) begin
                int g;
                txn_t t;
                g = model_pick(req_valid, ptr_m);
                check("grant_while_busy", busy, 0);
                if (g < 0) check("grant_spurious", req_ready, 0);
                else begin
                    check("grant_onehot", req_ready, NP'(1) << g);
                    t.port = g; t.wr = req_write[g]; t.addr = req_addr[g];
                    t.data = req_wdata[g];
                    // completion counted in cycles after issue; timeout fires at TO
                    t.err  = (ctl_mode != 0) || (!req_write[g] && rd_len > TO);
                    iss_q.push_back(t); rsp_q.push_back(t);
                    grant_log.push_back(g);
                    ptr_m = g; g_cnt++;
                    acc_mask = acc_mask | req_ready;
                end
            end
            if (rsp_valid != '0) begin
                last_rsp_valid = rsp_valid; last_err = rsp_error; last_rdata = rsp_rdata;
                r_cnt++;
                if (rsp_q.size() == 0) check("rsp_stale", rsp_valid, 0);
                else begin
                    txn_t t;
                    t = rsp_q.pop_front();
                    check("rsp_port", rsp_valid, NP'(1) << t.port);
                    check("rsp_error", rsp_error, t.err);
                    if (t.err) check("rsp_rdata_err", rsp_rdata, 0);
                    else if (!t.wr) check("rsp_rdata", rsp_rdata, rdf(t.addr));
                    else check("wr_rsp_after_busy", busy, 0);
                end
            end
        end
    end

    // controller-side issue monitor
    always @(negedge clk) begin
        if (rst_n && (wr_enable || rd_enable)) begin
            check("both_enables", wr_enable & rd_enable, 0);
            if (wr_enable) begin wr_pulses++; last_wr_addr = wr_addr; last_wr_data = wr_data; end
            if (rd_enable) begin rd_pulses++; last_rd_addr = rd_addr; end
            if (iss_q.size() == 0) check("issue_unexpected", 1, 0);
            else begin
                txn_t t;
                t = iss_q.pop_front();
                check("issue_write", wr_enable, t.wr);
                check("issue_addr", wr_enable ? wr_addr : rd_addr, t.addr);
                if (t.wr) check("issue_data", wr_data, t.data);
                check("issue_grant_idx", grant_idx, t.port);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_on = 0, hold_on = 0;

    task automatic new_req(int i);
        req_valid[i] = 1'b1;
        req_write[i] = 1'($urandom);
        req_addr[i]  = AW'($urandom);
        req_wdata[i] = DW'($urandom);
    endtask

    task automatic set_req(int i, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
        req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        for (int i = 0; i < NP; i++) begin
            if (acc_mask[i]) begin
                acc_mask[i] = 1'b0;
                if (hold_on || (rnd_on && $urandom_range(0, 1) == 1)) new_req(i);
                else req_valid[i] = 1'b0;
            end else if (rnd_on) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) new_req(i);
                else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while (!(rsp_q.size() == 0 && iss_q.size() == 0 && req_valid == '0 && !busy)
               && n < budget) begin
            tick(); n++;
        end
        check(name, n < budget, 1);
        tick();
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int n, p0, g0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        #23;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_enables", {wr_enable, rd_enable, rsp_error}, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // single read, port 1
        set_req(1, 1'b0, 24'h012345, 16'h0);
        wait_idle("drain_read", 100);
        check("read_pulses", rd_pulses, 1);
        check("read_addr", last_rd_addr, 24'h012345);
        check("read_rsp_valid", last_rsp_valid, 4'b0010);
        check("read_rdata", last_rdata, 16'hBEEF);
        check("read_err", last_err, 0);

        // single write, port 0
        set_req(0, 1'b1, 24'h000010, 16'hA5A5);
        wait_idle("drain_write", 100);
        check("write_pulses", wr_pulses, 1);
        check("write_addr", last_wr_addr, 24'h000010);
        check("write_data", last_wr_data, 16'hA5A5);
        check("write_rsp_valid", last_rsp_valid, 4'b0001);

        // all ports continuously valid after reset: 0,1,2,3,0,1
        do_reset();
        grant_log.delete();
        hold_on = 1;
        for (int i = 0; i < NP; i++) new_req(i);
        n = 0;
        while (grant_log.size() < 6 && n < 300) begin tick(); n++; end
        hold_on = 0;
        wait_idle("drain_rr", 300);
        check("rr_count", grant_log.size() >= 6, 1);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("rr_order_%0d", i), grant_log[i], i % NP);

        // controller never goes busy -> timeout
        ctl_mode = 1;
        set_req(2, 1'b0, AW'($urandom), 16'h0);
        wait_idle("drain_tmo", 300);
        check("tmo_rsp_valid", last_rsp_valid, 4'b0100);
        check("tmo_err", last_err, 1);
        check("tmo_rdata", last_rdata, 0);
        ctl_mode = 0;
        set_req(2, 1'b1, AW'($urandom), DW'($urandom));
        wait_idle("drain_after_tmo", 100);
        check("after_tmo_err", last_err, 0);

        // read data landing on the expiry cycle wins; one cycle later times out
        rd_len = TO;
        set_req(3, 1'b0, 24'h00ABCD, 16'h0);
        wait_idle("drain_edge64", 300);
        check("edge64_err", last_err, 0);
        rd_len = TO + 1;
        set_req(3, 1'b0, 24'h00ABCD, 16'h0);
        wait_idle("drain_edge65", 300);
        check("edge65_err", last_err, 1);
        rd_len = 3;

        // busy held externally: no grant until it drops, then immediate
        ext_busy = 1'b1;
        g0 = g_cnt;
        set_req(3, 1'b0, 24'h000777, 16'h0);
        repeat (6) tick();
        check("busy_no_grant", g_cnt, g0);
        ext_busy = 1'b0;
        @(negedge clk);
        check("busy_release_grant", req_ready, 4'b1000);
        wait_idle("drain_busy", 100);

        // reset during WAIT_DONE
        rd_len = 10;
        p0 = rd_pulses;
        set_req(1, 1'b0, 24'h0000F0, 16'h0);
        n = 0;
        while (rd_pulses == p0 && n < 50) begin tick(); n++; end
        check("midrst_issue_seen", rd_pulses, p0 + 1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        req_valid = '0;
        rd_len = 3;
        set_req(0, 1'b1, 24'h000100, 16'h1111);
        set_req(2, 1'b1, 24'h000200, 16'h2222);
        #1;
        check("midrst_enables", {wr_enable, rd_enable, rsp_error}, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_grant_idx", grant_idx, 0);
        grant_log.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle("drain_midrst", 200);
        check("midrst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        // randomized traffic
        g0 = g_cnt; p0 = r_cnt;
        rd_len = $urandom_range(1, 6);
        rnd_on = 1;
        repeat (400) tick();
        rnd_on = 0;
        wait_idle("drain_random", 1000);
        check("random_all_answered", g_cnt - g0, r_cnt - p0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one sdram_controller user interface (wr_*/rd_*/busy/rd_ready) between NUM_PORTS independent requesters.
- Round-robin grant, one outstanding transaction at a time, per-transaction timeout with error response.
- Sits between client blocks (DMA, CPU bridge, video fetch) and the SDRAM controller.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8)
- HADDR_WIDTH, 24, host address width (bank+row+col), matches the controller
- DATA_WIDTH, 16, data word width, matches the controller
- TIMEOUT_CYCLES, 64, max cycles from issue to completion before an error response
- PORT_W, $clog2(NUM_PORTS), derived, grant index width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_write  in  NUM_PORTS  per-port 1=write, 0=read
- req_addr  in  NUM_PORTS*HADDR_WIDTH  per-port address, port i at slice i
- req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data
- req_ready  out  NUM_PORTS  one-hot accept pulse; transfer when valid&ready
- rsp_valid  out  NUM_PORTS  one-hot completion pulse to the owning port
- rsp_error  out  1  qualifies rsp_valid; 1 = timeout
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid of a read
- wr_addr  out  HADDR_WIDTH  to controller
- wr_data  out  DATA_WIDTH  to controller
- wr_enable  out  1  to controller, one-cycle pulse
- rd_addr  out  HADDR_WIDTH  to controller
- rd_enable  out  1  to controller, one-cycle pulse
- rd_data  in  DATA_WIDTH  from controller
- rd_ready  in  1  from controller, read data valid
- busy  in  1  from controller, operation in progress
- grant_idx  out  PORT_W  index of the current/last owner (debug)

Behaviour:
- Reset (async assert, sync deassert internally): state=ARB, all outputs 0, rr pointer=NUM_PORTS-1 so port 0 has first priority.
- States: ARB, ISSUE, WAIT_ACCEPT, WAIT_DONE, RESP.
- ARB: if busy=0 and any req_valid, pick the first valid port searching from ptr+1 with wrap.
  - Pulse req_ready[g] this cycle.
  - Latch write flag, addr and wdata; set grant_idx=g and ptr=g; go to ISSUE.
  - If busy=1, no grant is made.
- ISSUE: drive wr_addr/wr_data and wr_enable=1, or rd_addr and rd_enable=1, for exactly one cycle. Clear timer; go to WAIT_ACCEPT.
- Addresses and data stay stable from ISSUE until the next grant. The unused enable stays 0.
- WAIT_ACCEPT: busy=1 -> WAIT_DONE.
- WAIT_DONE:
  - Read: rd_ready=1 captures rd_data into rsp_rdata -> RESP.
  - Write: busy=0 -> RESP.
  - rd_ready during a write is ignored.
- Timer increments in WAIT_ACCEPT and WAIT_DONE. Reaching TIMEOUT_CYCLES-1 -> RESP with error=1 and rsp_rdata=0.
- RESP: rsp_valid[grant]=1 for one cycle, rsp_error set accordingly -> ARB.
  - Next grant can occur in the cycle after RESP at earliest.
  - Latency ARB->RESP is at least 4 cycles.
- Simultaneous requests: strict round-robin. A port that was just served has lowest priority next arbitration.
- Requests may drop req_valid before ready; no state is held for them.
- A requester changing inputs after its accept has no effect.
- rd_ready arriving in the same cycle as the timeout expiry: data wins, error=0.
- Reset mid-transaction aborts it: no rsp_valid is issued, and enables drop immediately.

Decomposition:
- sdram_pkg: arb_state_t enum, default widths, and TIMEOUT_CYCLES default. The controller's HADDR/DATA widths are shared from the same package.
- Sub-module rr_arbiter: combinational next-grant from the req vector and ptr, plus a one-hot/index output. Reusable elsewhere.

Test Plan:
- Single read port1, addr=0x012345: rd_enable pulses once with rd_addr=0x012345. Model returns 0xBEEF after 3 cycles. Expect rsp_valid=4'b0010, rsp_rdata=0xBEEF, rsp_error=0.
- Single write port0, addr=0x000010, data=0xA5A5: wr_enable pulses once with those values. Busy high for 2 cycles, then rsp_valid[0] after busy falls.
- All 4 ports valid continuously: grant order 0,1,2,3,0,1; every port is served once per 4 transactions.
- Controller never asserts busy: after 64 cycles, rsp_valid[owner]=1 with rsp_error=1 and rsp_rdata=0. Arbiter returns to ARB.
- busy held high externally at request time: no req_ready until busy=0, then grant is immediate.
- rst_n pulled low during WAIT_DONE: all outputs 0 immediately. After release, port 0 is granted first and no stale rsp_valid appears.
